// File: rtl/crc32_stream_engine_pkg.sv
// Shared CRC-32 constants, FSM state type and the single-byte MSB-first CRC step.
// Bit convention is CRC-32/BZIP2: non-reflected, init and final XOR all-ones.
package crc32_pkg;

   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } crc_state_e;

   function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc, input logic [7:0] din);
      logic [31:0] c;
      c = crc ^ {din, 24'h000000};
      for (int i = 0; i < 8; i++) begin
         c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_stream_engine_if.sv
// Beat stream into the CRC engine plus its per-frame result and statistics outputs.
interface crc32_stream_engine_if #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
);
   localparam int NB_W = $clog2(DATA_W / 8) + 1;

   logic              in_valid;
   logic              in_sof;
   logic              in_eof;
   logic [NB_W-1:0]   in_nbytes;
   logic [DATA_W-1:0] in_data;

   logic              crc_valid;
   logic [31:0]       crc_value;
   logic              crc_ok;
   logic              err_pulse;
   logic [CNT_W-1:0]  good_cnt;
   logic [CNT_W-1:0]  bad_cnt;

   modport master (
      output in_valid, in_sof, in_eof, in_nbytes, in_data,
      input  crc_valid, crc_value, crc_ok, err_pulse, good_cnt, bad_cnt
   );

   modport slave (
      input  in_valid, in_sof, in_eof, in_nbytes, in_data,
      output crc_valid, crc_value, crc_ok, err_pulse, good_cnt, bad_cnt
   );
endinterface

// File: rtl/crc32_stream_engine_lane_step.sv
// Combinational CRC update over the byte lanes of one beat, MSB lane first.
// On the last beat only the top nbytes lanes count; 0 or an oversized count means the full word.
module crc32_lane_step
   import crc32_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int NB_W   = $clog2(DATA_W / 8) + 1
) (
   input  logic [31:0]       crc_in,
   input  logic [DATA_W-1:0] data,
   input  logic [NB_W-1:0]   nbytes,
   input  logic              last,
   output logic [31:0]       crc_out
);

   localparam int NBYTES = DATA_W / 8;

   logic [NB_W-1:0] lanes;
   logic [31:0]     acc;

   always_comb begin
      lanes = NB_W'(NBYTES);
      if (last && (nbytes != '0) && (nbytes < NB_W'(NBYTES))) begin
         lanes = nbytes;
      end
   end

   // Every lane is stepped; the tap after the requested lane count is kept.
   always_comb begin
      acc     = crc_in;
      crc_out = crc_in;
      for (int i = 0; i < NBYTES; i++) begin
         acc = crc32_byte_step(acc, data[DATA_W-1-8*i -: 8]);
         if (NB_W'(i + 1) == lanes) begin
            crc_out = acc;
         end
      end
   end

endmodule

// File: rtl/crc32_stream_engine.sv
// Frame-aware CRC-32 engine: tracks sof/eof, issues the FCS one cycle after eof,
// checks the received-FCS residue and keeps saturating good/bad frame counts.
//
// state     | meaning
// ST_IDLE   | between frames; crc register parked at CRC_INIT
// ST_ACTIVE | inside a frame; crc register holds the running remainder
module crc32_stream_engine
   import crc32_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   crc32_stream_engine_if.slave  bus
);

   localparam int NB_W = $clog2(DATA_W / 8) + 1;

   crc_state_e       state_q, state_d;
   logic [31:0]      crc_q, crc_d;
   logic             crc_valid_q, crc_valid_d;
   logic [31:0]      crc_value_q, crc_value_d;
   logic             crc_ok_q, crc_ok_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] good_q, good_d;
   logic [CNT_W-1:0] bad_q, bad_d;

   logic [31:0]      crc_seed;
   logic [31:0]      step_out;
   logic             issue;

   // A sof beat always restarts from INIT, which also covers the abort path.
   assign crc_seed = bus.in_sof ? CRC_INIT : crc_q;

   crc32_lane_step #(
      .DATA_W (DATA_W),
      .NB_W   (NB_W)
   ) u_lane_step (
      .crc_in  (crc_seed),
      .data    (bus.in_data),
      .nbytes  (bus.in_nbytes),
      .last    (bus.in_eof),
      .crc_out (step_out)
   );

   always_comb begin
      state_d     = state_q;
      crc_d       = crc_q;
      crc_valid_d = 1'b0;
      crc_value_d = crc_value_q;
      crc_ok_d    = crc_ok_q;
      err_d       = 1'b0;
      good_d      = good_q;
      bad_d       = bad_q;
      issue       = 1'b0;

      if (bus.in_valid) begin
         if (bus.in_sof) begin
            err_d = (state_q == ST_ACTIVE);
            if (bus.in_eof) begin
               issue   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               crc_d   = step_out;
               state_d = ST_ACTIVE;
            end
         end else if (state_q == ST_IDLE) begin
            err_d = 1'b1;
         end else if (bus.in_eof) begin
            issue   = 1'b1;
            state_d = ST_IDLE;
         end else begin
            crc_d = step_out;
         end
      end

      if (issue) begin
         crc_d       = CRC_INIT;
         crc_valid_d = 1'b1;
         crc_value_d = ~step_out;
         crc_ok_d    = (step_out == CRC_RESIDUE);
         if (step_out == CRC_RESIDUE) begin
            if (good_q != {CNT_W{1'b1}}) good_d = good_q + CNT_W'(1);
         end else begin
            if (bad_q != {CNT_W{1'b1}}) bad_d = bad_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         crc_q       <= CRC_INIT;
         crc_valid_q <= 1'b0;
         crc_value_q <= 32'h0;
         crc_ok_q    <= 1'b0;
         err_q       <= 1'b0;
         good_q      <= '0;
         bad_q       <= '0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         crc_valid_q <= crc_valid_d;
         crc_value_q <= crc_value_d;
         crc_ok_q    <= crc_ok_d;
         err_q       <= err_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
      end
   end

   assign bus.crc_valid = crc_valid_q;
   assign bus.crc_value = crc_value_q;
   assign bus.crc_ok    = crc_ok_q;
   assign bus.err_pulse = err_q;
   assign bus.good_cnt  = good_q;
   assign bus.bad_cnt   = bad_q;

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Directed bench: 32-bit, 64-bit and 2-bit-counter engine instances driven with
// hand-computed CRC-32/BZIP2 frames ("123456789" -> FC891918, FCS residue -> 38FB2284).
module tb_crc32_stream_engine;

   logic clk = 1'b0;
   logic rst32, rst64, rsts;
   int   total = 0;
   int   nbad  = 0;

   always #5 clk = ~clk;

   crc32_stream_engine_if #(.DATA_W(32), .CNT_W(16)) if32 ();
   crc32_stream_engine_if #(.DATA_W(64), .CNT_W(16)) if64 ();
   crc32_stream_engine_if #(.DATA_W(32), .CNT_W(2))  ifs  ();

   crc32_stream_engine #(.DATA_W(32), .CNT_W(16)) u32 (.clk(clk), .rst(rst32), .bus(if32.slave));
   crc32_stream_engine #(.DATA_W(64), .CNT_W(16)) u64 (.clk(clk), .rst(rst64), .bus(if64.slave));
   crc32_stream_engine #(.DATA_W(32), .CNT_W(2))  usat (.clk(clk), .rst(rsts), .bus(ifs.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic b32(input logic sof, input logic eof, input logic [2:0] nb, input logic [31:0] d);
      if32.in_valid = 1'b1; if32.in_sof = sof; if32.in_eof = eof;
      if32.in_nbytes = nb; if32.in_data = d;
      tick();
      if32.in_valid = 1'b0; if32.in_sof = 1'b0; if32.in_eof = 1'b0;
   endtask

   task automatic b64(input logic sof, input logic eof, input logic [3:0] nb, input logic [63:0] d);
      if64.in_valid = 1'b1; if64.in_sof = sof; if64.in_eof = eof;
      if64.in_nbytes = nb; if64.in_data = d;
      tick();
      if64.in_valid = 1'b0; if64.in_sof = 1'b0; if64.in_eof = 1'b0;
   endtask

   task automatic bs(input logic sof, input logic eof, input logic [2:0] nb, input logic [31:0] d);
      ifs.in_valid = 1'b1; ifs.in_sof = sof; ifs.in_eof = eof;
      ifs.in_nbytes = nb; ifs.in_data = d;
      tick();
      ifs.in_valid = 1'b0; ifs.in_sof = 1'b0; ifs.in_eof = 1'b0;
   endtask

   initial begin
      rst32 = 1'b0; rst64 = 1'b0; rsts = 1'b0;
      if32.in_valid = 1'b0; if32.in_sof = 1'b0; if32.in_eof = 1'b0; if32.in_nbytes = '0; if32.in_data = '0;
      if64.in_valid = 1'b0; if64.in_sof = 1'b0; if64.in_eof = 1'b0; if64.in_nbytes = '0; if64.in_data = '0;
      ifs.in_valid  = 1'b0; ifs.in_sof  = 1'b0; ifs.in_eof  = 1'b0; ifs.in_nbytes  = '0; ifs.in_data  = '0;
      tick(); tick();

      chk("rst_valid32", 64'(if32.crc_valid), 64'h0);
      chk("rst_value32", 64'(if32.crc_value), 64'h0);
      chk("rst_ok32",    64'(if32.crc_ok),    64'h0);
      chk("rst_err32",   64'(if32.err_pulse), 64'h0);
      chk("rst_good32",  64'(if32.good_cnt),  64'h0);
      chk("rst_bad32",   64'(if32.bad_cnt),   64'h0);
      chk("rst_value64", 64'(if64.crc_value), 64'h0);
      chk("rst_goods",   64'(ifs.good_cnt),   64'h0);
      rst32 = 1'b1; rst64 = 1'b1; rsts = 1'b1;

      // reset mid-frame discards the partial frame
      b32(1'b1, 1'b0, 3'd0, 32'h31323334);
      b32(1'b0, 1'b0, 3'd0, 32'h35363738);
      rst32 = 1'b0;
      tick();
      rst32 = 1'b1;
      chk("rstmid_valid", 64'(if32.crc_valid), 64'h0);
      chk("rstmid_good",  64'(if32.good_cnt),  64'h0);
      chk("rstmid_bad",   64'(if32.bad_cnt),   64'h0);
      tick();
      chk("rstmid_valid2", 64'(if32.crc_valid), 64'h0);

      // "123456789" with idle gaps mid-frame
      b32(1'b1, 1'b0, 3'd0, 32'h31323334);
      tick();
      b32(1'b0, 1'b0, 3'd0, 32'h35363738);
      tick();
      b32(1'b0, 1'b1, 3'd1, 32'h39000000);
      chk("a_valid", 64'(if32.crc_valid), 64'h1);
      chk("a_value", 64'(if32.crc_value), 64'hFC891918);
      chk("a_ok",    64'(if32.crc_ok),    64'h0);
      chk("a_bad",   64'(if32.bad_cnt),   64'h1);
      chk("a_good",  64'(if32.good_cnt),  64'h0);
      tick();
      chk("a_pulse_end", 64'(if32.crc_valid), 64'h0);
      chk("a_hold",      64'(if32.crc_value), 64'hFC891918);

      // same frame with its FCS appended -> residue
      b32(1'b1, 1'b0, 3'd0, 32'h31323334);
      b32(1'b0, 1'b0, 3'd0, 32'h35363738);
      b32(1'b0, 1'b0, 3'd0, 32'h39FC8919);
      chk("b_noearly", 64'(if32.crc_valid), 64'h0);
      b32(1'b0, 1'b1, 3'd1, 32'h18000000);
      chk("b_valid", 64'(if32.crc_valid), 64'h1);
      chk("b_ok",    64'(if32.crc_ok),    64'h1);
      chk("b_value", 64'(if32.crc_value), 64'h38FB2284);
      chk("b_good",  64'(if32.good_cnt),  64'h1);

      // one payload bit flipped
      b32(1'b1, 1'b0, 3'd0, 32'h31323335);
      b32(1'b0, 1'b0, 3'd0, 32'h35363738);
      b32(1'b0, 1'b0, 3'd0, 32'h39FC8919);
      b32(1'b0, 1'b1, 3'd1, 32'h18000000);
      chk("c_valid", 64'(if32.crc_valid), 64'h1);
      chk("c_ok",    64'(if32.crc_ok),    64'h0);
      chk("c_bad",   64'(if32.bad_cnt),   64'h2);
      chk("c_good",  64'(if32.good_cnt),  64'h1);

      // empty-message FCS (00000000) as a full word: nbytes=0, then oversized nbytes=5
      b32(1'b1, 1'b1, 3'd0, 32'h00000000);
      chk("nb0_ok",    64'(if32.crc_ok),    64'h1);
      chk("nb0_value", 64'(if32.crc_value), 64'h38FB2284);
      b32(1'b1, 1'b1, 3'd5, 32'h00000000);
      chk("nb5_valid", 64'(if32.crc_valid), 64'h1);
      chk("nb5_ok",    64'(if32.crc_ok),    64'h1);
      chk("nb5_good",  64'(if32.good_cnt),  64'h3);

      // beat with no sof while idle
      b32(1'b0, 1'b0, 3'd0, 32'h12345678);
      chk("nosof_err",   64'(if32.err_pulse), 64'h1);
      chk("nosof_valid", 64'(if32.crc_valid), 64'h0);
      tick();
      chk("nosof_err_end", 64'(if32.err_pulse), 64'h0);

      // sof inside a frame aborts and restarts
      b32(1'b1, 1'b0, 3'd0, 32'h31323334);
      chk("abort_noerr", 64'(if32.err_pulse), 64'h0);
      b32(1'b1, 1'b0, 3'd0, 32'h31323334);
      chk("abort_err",   64'(if32.err_pulse), 64'h1);
      chk("abort_valid", 64'(if32.crc_valid), 64'h0);
      b32(1'b0, 1'b0, 3'd0, 32'h35363738);
      chk("abort_err_end", 64'(if32.err_pulse), 64'h0);
      b32(1'b0, 1'b1, 3'd1, 32'h39000000);
      chk("abort_value", 64'(if32.crc_value), 64'hFC891918);
      chk("abort_bad",   64'(if32.bad_cnt),   64'h3);
      chk("abort_good",  64'(if32.good_cnt),  64'h3);

      // 64-bit: two single-beat frames back to back, garbage in unused lanes
      b64(1'b1, 1'b1, 4'd4, 64'h00000000DEADBEEF);
      chk("w_x1_valid", 64'(if64.crc_valid), 64'h1);
      chk("w_x1_value", 64'(if64.crc_value), 64'h38FB2284);
      b64(1'b1, 1'b1, 4'd4, 64'h0000000012345678);
      chk("w_x2_valid", 64'(if64.crc_valid), 64'h1);
      chk("w_x2_good",  64'(if64.good_cnt),  64'h2);
      chk("w_x2_err",   64'(if64.err_pulse), 64'h0);
      b64(1'b1, 1'b0, 4'd0, 64'h3132333435363738);
      chk("w_y1_gap", 64'(if64.crc_valid), 64'h0);
      b64(1'b0, 1'b1, 4'd1, 64'h39AABBCCDDEEFF00);
      chk("w_y1_valid", 64'(if64.crc_valid), 64'h1);
      chk("w_y1_value", 64'(if64.crc_value), 64'hFC891918);
      b64(1'b1, 1'b0, 4'd0, 64'h3132333435363738);
      chk("w_y2_gap", 64'(if64.crc_valid), 64'h0);
      b64(1'b0, 1'b1, 4'd1, 64'h3911223344556677);
      chk("w_y2_valid", 64'(if64.crc_valid), 64'h1);
      chk("w_y2_value", 64'(if64.crc_value), 64'hFC891918);
      chk("w_y2_bad",   64'(if64.bad_cnt),   64'h2);
      b64(1'b1, 1'b0, 4'd0, 64'h3132333435363738);
      b64(1'b0, 1'b1, 4'd5, 64'h39FC891918A5A5A5);
      chk("w_fcs_ok",   64'(if64.crc_ok),   64'h1);
      chk("w_fcs_good", 64'(if64.good_cnt), 64'h3);

      // 2-bit counters saturate at 3
      bs(1'b1, 1'b1, 3'd0, 32'h00000000);
      chk("sat_1", 64'(ifs.good_cnt), 64'h1);
      bs(1'b1, 1'b1, 3'd0, 32'h00000000);
      chk("sat_2", 64'(ifs.good_cnt), 64'h2);
      bs(1'b1, 1'b1, 3'd0, 32'h00000000);
      chk("sat_3", 64'(ifs.good_cnt), 64'h3);
      bs(1'b1, 1'b1, 3'd0, 32'h00000000);
      chk("sat_4", 64'(ifs.good_cnt), 64'h3);
      bs(1'b1, 1'b1, 3'd0, 32'h00000000);
      chk("sat_5",     64'(ifs.good_cnt), 64'h3);
      chk("sat_bad",   64'(ifs.bad_cnt),  64'h0);
      chk("sat_valid", 64'(ifs.crc_valid), 64'h1);

      tick();
      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end

endmodule
